// File: rtl/key_pack_pkg.sv
// Shared types and widths for the keypad nibble-packing front end.
package key_pack_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/key_timer.sv
// Inactivity timer for a held high nibble; saturates at TIMEOUT_CYCLES-1 and flags expiry.
module key_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = run && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/key_pack.sv
// Packs hex key presses into bytes (high nibble first) for the PIN checker,
// with stale-nibble timeout, per-attempt byte limit and a clear-to-restart pulse.
module key_pack
    import key_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_BYTES      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NIBBLE_W-1:0] key_code,
    input  logic                key_valid,
    input  logic                key_clear,
    output logic [BYTE_W-1:0]   din,
    output logic                din_valid,
    output logic [2:0]          byte_count,
    output logic                timeout,
    output logic                restart
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_BYTES);

    state_t              state_q, state_d;
    logic [NIBBLE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0]   din_q, din_d;
    logic                din_valid_q, din_valid_d;
    logic [2:0]          byte_count_q, byte_count_d;
    logic                timeout_q, timeout_d;
    logic                restart_q, restart_d;
    logic                expired;

    // Timer is held at zero outside HALF, so entering HALF always starts a fresh window.
    key_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state_q == HALF),
        .clr    (state_q != HALF),
        .expired(expired)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        din_d        = din_q;
        din_valid_d  = 1'b0;
        byte_count_d = byte_count_q;
        timeout_d    = 1'b0;
        restart_d    = 1'b0;

        if (key_clear) begin
            state_d      = IDLE;
            byte_count_d = '0;
            restart_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        hi_d    = key_code;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (key_valid) begin
                        din_d        = {hi_q, key_code};
                        din_valid_d  = 1'b1;
                        byte_count_d = byte_count_q + 3'd1;
                        state_d      = (byte_count_d == MAX_CNT) ? DONE : IDLE;
                    end else if (expired) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            din_q        <= '0;
            din_valid_q  <= 1'b0;
            byte_count_q <= '0;
            timeout_q    <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            din_q        <= din_d;
            din_valid_q  <= din_valid_d;
            byte_count_q <= byte_count_d;
            timeout_q    <= timeout_d;
            restart_q    <= restart_d;
        end
    end

    assign din        = din_q;
    assign din_valid  = din_valid_q;
    assign byte_count = byte_count_q;
    assign timeout    = timeout_q;
    assign restart    = restart_q;

endmodule

// File: tb/tb_key_pack.sv
// Self-checking bench for key_pack: directed test-plan scenarios plus random traffic
// against a cycle-level behavioural model of the key-entry rules.
module tb_key_pack;

    localparam int unsigned T_CYC = 8;
    localparam int unsigned MAX_B = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_clear;
    logic [7:0] din;
    logic       din_valid;
    logic [2:0] byte_count;
    logic       timeout;
    logic       restart;

    key_pack #(
        .TIMEOUT_CYCLES(T_CYC),
        .MAX_BYTES     (MAX_B)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_clear (key_clear),
        .din       (din),
        .din_valid (din_valid),
        .byte_count(byte_count),
        .timeout   (timeout),
        .restart   (restart)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a held nibble, its age in idle cycles, and bytes sent this attempt.
    bit         m_held;
    logic [3:0] m_hi;
    int         m_age;
    int         m_count;
    logic [7:0] m_din;
    bit         m_dv, m_to, m_rs;

    logic [7:0] beats[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit clr, input bit vld, input logic [3:0] code);
        m_dv = 0; m_to = 0; m_rs = 0;
        if (!rst_n) begin
            m_held = 0; m_hi = '0; m_age = 0; m_count = 0; m_din = '0;
        end else if (clr) begin
            m_held = 0; m_count = 0; m_rs = 1;
        end else if (vld && m_count < int'(MAX_B)) begin
            if (!m_held) begin
                m_held = 1; m_hi = code; m_age = 0;
            end else begin
                m_din = {m_hi, code}; m_dv = 1; m_count++; m_held = 0;
            end
        end else if (m_held) begin
            if (m_age == int'(T_CYC) - 1) begin
                m_to = 1; m_held = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic cycle(input bit rst_n, input bit clr, input bit vld, input logic [3:0] code);
        reset_n   = rst_n;
        key_clear = clr;
        key_valid = vld;
        key_code  = code;
        @(posedge clk);
        model_step(rst_n, clr, vld, code);
        #1;
        check("din",        32'(din),        32'(m_din));
        check("din_valid",  32'(din_valid),  32'(m_dv));
        check("byte_count", 32'(byte_count), 32'(m_count));
        check("timeout",    32'(timeout),    32'(m_to));
        check("restart",    32'(restart),    32'(m_rs));
        if (din_valid) beats.push_back(din);
    endtask

    task automatic key(input logic [3:0] c);
        cycle(1, 0, 1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 4'h0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 4'h0);
        cycle(0, 0, 0, 4'h0);
        beats.delete();
    endtask

    task automatic check_beats(input string tag, input logic [7:0] exp[$]);
        check({tag, "_n"}, 32'(beats.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < beats.size(); i++)
            check(tag, 32'(beats[i]), 32'(exp[i]));
        beats.delete();
    endtask

    initial begin
        logic [3:0] code_seq[8];
        int first_to;

        reset_n = 0; key_clear = 0; key_valid = 0; key_code = '0;
        m_held = 0; m_hi = '0; m_age = 0; m_count = 0; m_din = '0;

        do_reset();
        check("rst_din", 32'(din), 32'h00);
        check("rst_cnt", 32'(byte_count), 32'd0);

        // Correct code entry, keys 3 cycles apart, then an ignored ninth key.
        code_seq = '{4'hb, 4'ha, 4'ha, 4'hd, 4'hc, 4'h0, 4'hd, 4'he};
        foreach (code_seq[i]) begin
            key(code_seq[i]);
            idle(2);
        end
        key(4'h1);
        idle(3);
        check("entry_cnt", 32'(byte_count), 32'd4);
        check_beats("entry", '{8'hba, 8'had, 8'hc0, 8'hde});
        cycle(1, 1, 0, 4'h0);

        // Timeout: pulse seen after the 8th edge following the key.
        key(4'hb);
        first_to = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(1, 0, 0, 4'h0);
            if (timeout && first_to == 0) first_to = i;
        end
        check("to_latency", 32'(first_to), 32'd8);
        check("to_cnt", 32'(byte_count), 32'd0);
        key(4'ha); key(4'hd);
        idle(1);
        check_beats("after_to", '{8'had});

        // Timeout race: second key in the expiring cycle wins.
        key(4'hb);
        idle(int'(T_CYC) - 1);
        key(4'ha);
        idle(3);
        check_beats("race", '{8'hba});

        // Clear mid-byte, then clear together with key_valid in HALF.
        key(4'h7);
        cycle(1, 1, 0, 4'h0);
        key(4'h5);
        cycle(1, 1, 1, 4'h6);
        idle(1);
        check("clr_cnt", 32'(byte_count), 32'd0);
        key(4'h1); key(4'h2);
        idle(1);
        check_beats("clear", '{8'h12});

        // Back-to-back keys.
        key(4'hf); key(4'hf); key(4'h0); key(4'h0);
        idle(1);
        check_beats("b2b", '{8'hff, 8'h00});

        // Reset mid-byte.
        key(4'h9);
        cycle(0, 0, 0, 4'h0);
        check("rstmid_dv", 32'(din_valid), 32'd0);
        check("rstmid_din", 32'(din), 32'h00);
        key(4'h3); key(4'h4);
        idle(1);
        check_beats("rstmid", '{8'h34});

        // Random traffic: phases of dense and sparse keys to exercise timeouts and DONE.
        for (int i = 0; i < 3000; i++) begin
            int unsigned rate;
            rate = (i / 500) % 2 == 0 ? 3 : 11;
            cycle(($urandom % 250) != 0,
                  ($urandom % 60) == 0,
                  ($urandom % rate) == 0,
                  4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_pack.md
# key_pack

Keypad-entry front end for the safe lock. Accepts one hex key press at a time as a 4-bit nibble and packs nibble pairs, high nibble first, into bytes. Each byte goes out as a one-cycle `din`/`din_valid` beat to the PIN-checking stage directly downstream. It also drops stale half-bytes after an inactivity timeout, and turns a clear key into a restart pulse for the downstream checker.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed while a high nibble is held before it is discarded; legal range ≥ 2.
- `MAX_BYTES`, default 4: bytes emitted per entry attempt; further keys are ignored until clear or reset.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `posedge clk`.
- `key_code`  in  4  hex digit of the current key press.
- `key_valid`  in  1  `key_code` is valid this cycle; one key per asserted cycle.
- `key_clear`  in  1  abandon entry; one-cycle pulse or level.
- `din`  out  8  packed byte; holds its last value between beats.
- `din_valid`  out  1  one-cycle pulse, `din` valid.
- `byte_count`  out  3  bytes emitted since the last clear/reset, saturating at `MAX_BYTES`.
- `timeout`  out  1  one-cycle pulse: held nibble discarded.
- `restart`  out  1  one-cycle pulse on clear; wired to the downstream checker's active-high reset.

## Operation
- States:
  - IDLE: no nibble held.
  - HALF: high nibble held.
  - DONE: `byte_count == MAX_BYTES`.
- IDLE + `key_valid`:
  - latch `key_code` as the high nibble;
  - go to HALF;
  - clear the timer.
- HALF + `key_valid`:
  - `din <= {hi, key_code}`;
  - `din_valid <= 1`;
  - `byte_count++`;
  - go to DONE if the new count equals `MAX_BYTES`, else IDLE.
- HALF without a key:
  - the timer increments every cycle;
  - when the timer reaches `TIMEOUT_CYCLES - 1` with no key that cycle: `timeout <= 1`, return to IDLE, discard the nibble;
  - `byte_count` is unchanged.
- DONE: `key_valid` is ignored and produces no output.
- `key_clear` in any state:
  - go to IDLE, discard any nibble;
  - `byte_count <= 0`, `restart <= 1`;
  - `din_valid` stays 0.
- Priority, highest first: `reset_n` low, then `key_clear`, then `key_valid`, then timeout.
  - `key_valid` in the timeout cycle wins: the byte is emitted and no timeout fires.
- No arithmetic on data. The timer is `$clog2(TIMEOUT_CYCLES)` bits wide, counts only in HALF, and never wraps.

## Timing
- Reset values: `din = 8'h00`; `din_valid`, `timeout`, `restart` = 0; `byte_count = 0`; state IDLE; timer 0.
- Latency: `din_valid` is high in the cycle after the second nibble's `key_valid` cycle, i.e. a registered output.
- `restart` is high in the cycle after the `key_clear` cycle.
- `timeout` is high in the cycle after the expiring cycle.
- No backpressure: the downstream stage accepts every beat.
- Back-to-back keys every cycle are legal and give one byte every 2 cycles.
- Reset asserted mid-byte: the nibble is lost and no beat is emitted.

## Structure
- Package `key_pack_pkg`:
  - state enum `{IDLE, HALF, DONE}`;
  - `NIBBLE_W = 4`, `BYTE_W = 8`.
- Sub-module `key_timer`:
  - parameter `TIMEOUT_CYCLES`;
  - inputs `clk`, `reset_n`, `run`, `clr`;
  - output `expired`: one-cycle level, high when count equals `TIMEOUT_CYCLES - 1` and `run` is high.
- The FSM and output registers live in `key_pack`.

## Test plan
- **Correct code entry.** Keys `b,a,a,d,c,0,d,e`, spaced 3 cycles apart.
  - Expect four `din_valid` beats: `0xba`, `0xad`, `0xc0`, `0xde`.
  - Then `byte_count = 4` and DONE.
  - A ninth key `1` gives no beat.
- **Timeout.** `TIMEOUT_CYCLES = 8`: key `b`, then idle.
  - Expect a `timeout` pulse exactly 8 cycles after the `b` cycle, and `byte_count` stays 0.
  - Then keys `a,d` give `din = 0xad`.
- **Timeout race.** Key `b`, then key `a` exactly in the expiring cycle.
  - Expect `din = 0xba` and no `timeout` pulse.
- **Clear.** Clear mid-byte, and clear together with `key_valid` in HALF.
  - Expect no `din_valid`, one `restart` pulse, `byte_count = 0`.
  - The next keys `1,2` give `0x12`.
- **Back-to-back.** Keys `f,f,0,0` on consecutive cycles.
  - Expect beats `0xff` and `0x00`, 2 cycles apart.
- **Reset mid-byte.** `reset_n` low for 1 cycle while in HALF.
  - All outputs go to their reset values, with no beat.
  - The following `3,4` gives `0x34`.
